ram_access_arbiter: RTL and testbench
=====================================

RAM_ACCESS_ARBITER -- requirements
Module: ram_access_arbiter

Interface
REQ-001 Parameter DATA_W, default 46, RAM data width in bits (movie record).
REQ-002 Parameter TIMEOUT, default 1023, maximum BUSY cycles to wait for over_i.
REQ-003 Clock is clk; reset is rst_n, asynchronous, active-low.
REQ-004 clk  in  1  system clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 en_i  in  1  enables new grants; an in-flight transaction completes regardless.
REQ-007 req_i  in  3  request per requester: bit0 buy, bit1 refund, bit2 vip.
REQ-008 op_i  in  9  3-bit RAM op per requester, requester k at [3k+2:3k].
REQ-009 index_i  in  96  32-bit index per requester.
REQ-010 id_i  in  18  6-bit id per requester.
REQ-011 wdata_i  in  3*DATA_W  write data per requester.
REQ-012 gnt_o  out  3  one-hot owner of RAM port; all-zero when idle.
REQ-013 done_o  out  3  one-cycle completion pulse to the owner.
REQ-014 wrong_o  out  1  error flag, valid while done_o is nonzero.
REQ-015 timeout_o  out  1  one-cycle pulse on timeout completion.
REQ-016 rdata_o  out  DATA_W  data captured from RAM at completion; held until next completion.
REQ-017 ram_op_o / ram_index_o / ram_id_o / ram_data_o  out  3/32/6/DATA_W  RAM command port.
REQ-018 ram_over_i / ram_wrong_i  in  1/1  RAM completion and error.
REQ-019 ram_data_i  in  DATA_W  RAM read data.

Function
REQ-020 FSM states: IDLE, BUSY, DONE.
REQ-021 IDLE: ram_op_o = 3'b111 (none); gnt_o = 0. If en_i=1 and req_i≠0, winner is chosen round-robin starting at (last+1) mod 3. The winner's op, index, id and wdata are latched, gnt_o is set, and the FSM enters BUSY next cycle.
REQ-022 Round-robin pointer last updates only on grant; reset value is 2, so requester 0 has first priority.
REQ-023 BUSY: ram_op_o, ram_index_o, ram_id_o and ram_data_o drive the latched values continuously; inputs from any requester are ignored.
REQ-024 BUSY with ram_over_i=1: capture ram_data_i into rdata_o and ram_wrong_i into the wrong register; enter DONE.
REQ-025 DONE, exactly 1 cycle: done_o = gnt_o; wrong_o valid; ram_op_o = 3'b111; then IDLE with gnt_o cleared.
REQ-026 Latency: req sampled in IDLE at cycle N gives gnt_o and command at N+1. ram_over_i at cycle M gives done_o at M+1 and IDLE at M+2.
REQ-027 Owner deasserts req_i on the edge after done_o; req_i still high in IDLE is a new request.
REQ-028 A granted op of 3'b111 goes BUSY→DONE on the next cycle with wrong_o=1 and no RAM command; rdata_o is unchanged.
REQ-029 Timeout: a 10-bit counter clears on entering BUSY and increments each BUSY cycle without ram_over_i. At count==TIMEOUT the FSM enters DONE with wrong_o=1 and timeout_o=1; rdata_o is unchanged.
REQ-030 Owner deasserting req_i during BUSY does not abort; done_o is still pulsed.
REQ-031 en_i falling during BUSY does not abort the transaction; no grant is issued while en_i=0.
REQ-032 ram_over_i and ram_wrong_i sampled simultaneously complete the transaction with wrong_o=1 and data captured.
REQ-033 ram_over_i in IDLE or DONE is ignored.
REQ-034 gnt_o is never multi-hot.

Reset
REQ-035 Asynchronous assertion sets: state IDLE, gnt_o=0, done_o=0, wrong_o=0, timeout_o=0, rdata_o=0, ram_op_o=3'b111, ram_index_o=0, ram_id_o=0, ram_data_o=0, counter=0, last=2.
REQ-036 Reset during BUSY abandons the transaction with no done_o pulse.

Structure
REQ-037 Package client_pkg holds: op codes (none=3'b111), requester indices (REQ_BUY=0, REQ_REFUND=1, REQ_VIP=2), and the FSM state encoding.
REQ-038 Sub-module rr_arbiter3 is combinational. It takes req[2:0] and last[1:0] and produces one-hot grant plus an encoded index.

Verification
REQ-039 Basic read: req_i=001, op 3'b000, index 5. Expect gnt_o=001 at N+1. ram_over_i with ram_data_i=46'h123 at M gives done_o=001 at M+1, rdata_o=46'h123 and wrong_o=0.
REQ-040 Fairness: req_i=111 held, each transaction 3 cycles. Grants go 001, 010, 100, 001.
REQ-041 Timeout: TIMEOUT=8, RAM silent. Expect done_o and timeout_o after 8 BUSY cycles, wrong_o=1, rdata_o unchanged.
REQ-042 Error: ram_over_i=1 and ram_wrong_i=1 together. Expect wrong_o=1, done_o to the owner, IDLE 2 cycles later.
REQ-043 Reset mid-BUSY: rst_n low at BUSY cycle 3. Outputs take REQ-035 values immediately and no done_o pulse follows.
REQ-044 Gating: en_i=0 with req_i=010. No grant is issued; en_i=1 gives a grant on the next cycle.

Source files
------------

// File: rtl/client_pkg.sv
// Shared definitions for the RAM access arbiter: op codes, requester
// indices, FSM state encoding and the round-robin pointer helper.
package client_pkg;

    localparam int unsigned N_REQ = 3;
    localparam int unsigned CNT_W = 10;

    localparam logic [2:0] OP_READ  = 3'b000;
    localparam logic [2:0] OP_WRITE = 3'b001;
    localparam logic [2:0] OP_NONE  = 3'b111;

    localparam logic [1:0] REQ_BUY    = 2'd0;
    localparam logic [1:0] REQ_REFUND = 2'd1;
    localparam logic [1:0] REQ_VIP    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Next requester index in the 0 -> 1 -> 2 -> 0 rotation.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx >= REQ_VIP) ? REQ_BUY : idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Combinational 3-way round-robin arbiter. Search starts at the requester
// after 'last'; produces a one-hot grant and its encoded index.
module rr_arbiter3 import client_pkg::*; (
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [2:0] grant,
    output logic [1:0] idx
);

    logic [1:0] cand;

    // Walk the three candidates in rotation order, first requester wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        cand  = rr_next(last);
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant == '0 && req[cand]) begin
                grant[cand] = 1'b1;
                idx         = cand;
            end
            cand = rr_next(cand);
        end
    end

endmodule

// File: rtl/ram_access_arbiter.sv
// Arbitrates three requesters (buy, refund, vip) onto a single RAM command
// port. IDLE -> BUSY -> DONE, one transaction at a time, with a BUSY timeout.
module ram_access_arbiter import client_pkg::*; #(
    parameter int unsigned DATA_W  = 46,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    input  logic [2:0]            req_i,
    input  logic [8:0]            op_i,
    input  logic [95:0]           index_i,
    input  logic [17:0]           id_i,
    input  logic [3*DATA_W-1:0]   wdata_i,
    output logic [2:0]            gnt_o,
    output logic [2:0]            done_o,
    output logic                  wrong_o,
    output logic                  timeout_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic [2:0]            ram_op_o,
    output logic [31:0]           ram_index_o,
    output logic [5:0]            ram_id_o,
    output logic [DATA_W-1:0]     ram_data_o,
    input  logic                  ram_over_i,
    input  logic                  ram_wrong_i,
    input  logic [DATA_W-1:0]     ram_data_i
);

    state_t             state;
    logic [1:0]         last;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_inc;
    logic               tmo_hit;

    logic [2:0]         rr_grant;
    logic [1:0]         rr_idx;

    logic [2:0]         win_op;
    logic [31:0]        win_index;
    logic [5:0]         win_id;
    logic [DATA_W-1:0]  win_data;

    rr_arbiter3 u_rr (
        .req   (req_i),
        .last  (last),
        .grant (rr_grant),
        .idx   (rr_idx)
    );

    // Select the command fields of the requester the arbiter would grant.
    always_comb begin
        win_op    = OP_NONE;
        win_index = '0;
        win_id    = '0;
        win_data  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (rr_grant[k]) begin
                win_op    = op_i[3*k +: 3];
                win_index = index_i[32*k +: 32];
                win_id    = id_i[6*k +: 6];
                win_data  = wdata_i[DATA_W*k +: DATA_W];
            end
        end
    end

    // Timeout fires on the BUSY cycle whose increment would reach TIMEOUT,
    // so BUSY lasts exactly TIMEOUT cycles when the RAM stays silent.
    always_comb begin
        cnt_inc = cnt + 1'b1;
        tmo_hit = (32'(cnt) + 32'd1) >= TIMEOUT;
    end

    // Transaction FSM; every output is registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            last        <= REQ_VIP;
            cnt         <= '0;
            gnt_o       <= '0;
            done_o      <= '0;
            wrong_o     <= 1'b0;
            timeout_o   <= 1'b0;
            rdata_o     <= '0;
            ram_op_o    <= OP_NONE;
            ram_index_o <= '0;
            ram_id_o    <= '0;
            ram_data_o  <= '0;
        end else begin
            done_o    <= '0;
            timeout_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (en_i && req_i != '0) begin
                        state       <= ST_BUSY;
                        gnt_o       <= rr_grant;
                        last        <= rr_idx;
                        cnt         <= '0;
                        ram_op_o    <= win_op;
                        ram_index_o <= win_index;
                        ram_id_o    <= win_id;
                        ram_data_o  <= win_data;
                    end
                end
                ST_BUSY: begin
                    if (ram_op_o == OP_NONE) begin
                        // Nothing was issued to the RAM: fail immediately.
                        state   <= ST_DONE;
                        done_o  <= gnt_o;
                        wrong_o <= 1'b1;
                    end else if (ram_over_i) begin
                        state    <= ST_DONE;
                        done_o   <= gnt_o;
                        wrong_o  <= ram_wrong_i;
                        rdata_o  <= ram_data_i;
                        ram_op_o <= OP_NONE;
                    end else if (tmo_hit) begin
                        state     <= ST_DONE;
                        done_o    <= gnt_o;
                        wrong_o   <= 1'b1;
                        timeout_o <= 1'b1;
                        ram_op_o  <= OP_NONE;
                        cnt       <= cnt_inc;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    gnt_o   <= '0;
                    wrong_o <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Self-checking bench for ram_access_arbiter: table of transactions plus
// hand-written corner sequences, completions checked by a scoreboard.
module tb_ram_access_arbiter;
    import client_pkg::*;

    localparam int unsigned DW  = 46;
    localparam int unsigned TMO = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en_i = 1'b0;
    logic [2:0]        req_i = '0;
    logic [8:0]        op_i;
    logic [95:0]       index_i;
    logic [17:0]       id_i;
    logic [3*DW-1:0]   wdata_i;
    logic [2:0]        gnt_o;
    logic [2:0]        done_o;
    logic              wrong_o;
    logic              timeout_o;
    logic [DW-1:0]     rdata_o;
    logic [2:0]        ram_op_o;
    logic [31:0]       ram_index_o;
    logic [5:0]        ram_id_o;
    logic [DW-1:0]     ram_data_o;
    logic              ram_over_i = 1'b0;
    logic              ram_wrong_i = 1'b0;
    logic [DW-1:0]     ram_data_i = '0;

    logic [2:0]        op_arr [3];

    typedef struct {
        logic [2:0]    gnt;
        logic          wrong;
        logic          timeout;
        logic [DW-1:0] rdata;
    } exp_t;

    typedef struct {
        logic [2:0]    req;
        int unsigned   lat;
        logic          rwrong;
        logic [DW-1:0] rdata;
        logic [2:0]    gnt;
        logic          wrong;
    } vec_t;

    exp_t          sb[$];
    vec_t          vecs[7];
    int unsigned   n_checks = 0;
    int unsigned   n_fail = 0;
    int unsigned   n_done = 0;
    int unsigned   done_snap;
    int unsigned   widx;
    logic [DW-1:0] exp_rdata;

    ram_access_arbiter #(.DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (en_i),
        .req_i       (req_i),
        .op_i        (op_i),
        .index_i     (index_i),
        .id_i        (id_i),
        .wdata_i     (wdata_i),
        .gnt_o       (gnt_o),
        .done_o      (done_o),
        .wrong_o     (wrong_o),
        .timeout_o   (timeout_o),
        .rdata_o     (rdata_o),
        .ram_op_o    (ram_op_o),
        .ram_index_o (ram_index_o),
        .ram_id_o    (ram_id_o),
        .ram_data_o  (ram_data_o),
        .ram_over_i  (ram_over_i),
        .ram_wrong_i (ram_wrong_i),
        .ram_data_i  (ram_data_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] req_index(input int unsigned k);
        return (k == 0) ? 32'd5 : 32'h1000_0000 + 32'(k);
    endfunction

    function automatic logic [5:0] req_id(input int unsigned k);
        return 6'(10 + k);
    endfunction

    function automatic logic [DW-1:0] req_wdata(input int unsigned k);
        return 46'h2A_0000_0000 + DW'(k);
    endfunction

    function automatic int unsigned oh_idx(input logic [2:0] g);
        return g[1] ? 1 : (g[2] ? 2 : 0);
    endfunction

    // Pack per-requester command fields onto the flat input buses.
    always_comb begin
        op_i    = '0;
        index_i = '0;
        id_i    = '0;
        wdata_i = '0;
        for (int k = 0; k < 3; k++) begin
            op_i[3*k +: 3]      = op_arr[k];
            index_i[32*k +: 32] = req_index(k);
            id_i[6*k +: 6]      = req_id(k);
            wdata_i[DW*k +: DW] = req_wdata(k);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_gnt"},   gnt_o, 3'b000);
        check({tag, "_done"},  done_o, 3'b000);
        check({tag, "_wrong"}, wrong_o, 1'b0);
        check({tag, "_tmo"},   timeout_o, 1'b0);
        check({tag, "_rdata"}, rdata_o, '0);
        check({tag, "_op"},    ram_op_o, OP_NONE);
        check({tag, "_index"}, ram_index_o, '0);
        check({tag, "_id"},    ram_id_o, '0);
        check({tag, "_data"},  ram_data_o, '0);
    endtask

    // Completion monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done_o != '0) begin
            n_done++;
            if (sb.size() == 0) begin
                check("unexpected_done", done_o, 3'b000);
            end else begin
                e = sb.pop_front();
                check("sb_done",    done_o, e.gnt);
                check("sb_gnt",     gnt_o, e.gnt);
                check("sb_wrong",   wrong_o, e.wrong);
                check("sb_timeout", timeout_o, e.timeout);
                check("sb_rdata",   rdata_o, e.rdata);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 3; k++) op_arr[k] = 3'(k);

        vecs[0] = '{3'b001, 2, 1'b0, 46'h123,            3'b001, 1'b0};
        vecs[1] = '{3'b111, 1, 1'b0, 46'h0A1,            3'b010, 1'b0};
        vecs[2] = '{3'b111, 1, 1'b0, 46'h0B2,            3'b100, 1'b0};
        vecs[3] = '{3'b111, 1, 1'b0, 46'h0C3,            3'b001, 1'b0};
        vecs[4] = '{3'b101, 3, 1'b0, 46'h3FFF_FFFF_FFFF, 3'b100, 1'b0};
        vecs[5] = '{3'b110, 1, 1'b1, 46'h0E5,            3'b010, 1'b1};
        vecs[6] = '{3'b011, 2, 1'b0, 46'h0F6,            3'b001, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst_n = 1'b1;
        tick();

        // RAM completion while idle must be ignored.
        ram_over_i = 1'b1;
        ram_data_i = 46'h3FF;
        tick();
        ram_over_i = 1'b0;
        check("idle_over_gnt",   gnt_o, 3'b000);
        check("idle_over_rdata", rdata_o, '0);

        // Table-driven transactions: grant order, command port, completion.
        en_i = 1'b1;
        foreach (vecs[i]) begin
            req_i = vecs[i].req;
            tick();
            widx = oh_idx(vecs[i].gnt);
            check("tbl_gnt",   gnt_o, vecs[i].gnt);
            check("tbl_op",    ram_op_o, op_arr[widx]);
            check("tbl_index", ram_index_o, req_index(widx));
            check("tbl_id",    ram_id_o, req_id(widx));
            check("tbl_wdata", ram_data_o, req_wdata(widx));
            sb.push_back('{vecs[i].gnt, vecs[i].wrong, 1'b0, vecs[i].rdata});
            exp_rdata = vecs[i].rdata;
            repeat (vecs[i].lat - 1) tick();
            ram_over_i  = 1'b1;
            ram_wrong_i = vecs[i].rwrong;
            ram_data_i  = vecs[i].rdata;
            tick();
            ram_over_i  = 1'b0;
            ram_wrong_i = 1'b0;
            check("tbl_done_op", ram_op_o, OP_NONE);
            tick();
            check("tbl_idle_gnt", gnt_o, 3'b000);
        end
        req_i = '0;

        // Granted no-op: immediate error completion, read data untouched.
        op_arr[1] = OP_NONE;
        req_i = 3'b010;
        tick();
        check("noop_gnt", gnt_o, 3'b010);
        check("noop_op",  ram_op_o, OP_NONE);
        sb.push_back('{3'b010, 1'b1, 1'b0, exp_rdata});
        tick();
        req_i = '0;
        tick();
        check("noop_idle", gnt_o, 3'b000);
        op_arr[1] = 3'd1;

        // Timeout with requester and enable dropped mid-transaction.
        req_i = 3'b100;
        tick();
        check("tmo_gnt", gnt_o, 3'b100);
        sb.push_back('{3'b100, 1'b1, 1'b1, exp_rdata});
        req_i = '0;
        en_i  = 1'b0;
        repeat (TMO - 1) tick();
        check("tmo_not_early", done_o, 3'b000);
        check("tmo_still_gnt", gnt_o, 3'b100);
        tick();
        tick();
        check("tmo_idle", gnt_o, 3'b000);

        // Enable gating: no grant while en_i is low.
        req_i = 3'b010;
        tick();
        check("gate_gnt_a", gnt_o, 3'b000);
        tick();
        check("gate_gnt_b", gnt_o, 3'b000);
        en_i = 1'b1;
        tick();
        check("gate_gnt_on", gnt_o, 3'b010);
        sb.push_back('{3'b010, 1'b0, 1'b0, 46'h55});
        ram_over_i = 1'b1;
        ram_data_i = 46'h55;
        tick();
        ram_over_i = 1'b0;
        req_i = '0;
        tick();

        // Reset in the third BUSY cycle abandons the transaction.
        req_i = 3'b001;
        tick();
        check("rst_busy_gnt", gnt_o, 3'b001);
        tick();
        tick();
        done_snap = n_done;
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        tick();
        tick();
        rst_n = 1'b1;
        req_i = '0;
        repeat (3) tick();
        check("midrst_no_done", n_done, done_snap);
        req_i = 3'b111;
        tick();
        check("midrst_ptr_gnt", gnt_o, 3'b001);
        sb.push_back('{3'b001, 1'b0, 1'b0, 46'h77});
        ram_over_i = 1'b1;
        ram_data_i = 46'h77;
        tick();
        ram_over_i = 1'b0;
        req_i = '0;
        repeat (2) tick();

        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
